// File: rtl/aes_stream_arbiter.sv
// rtl/aes_stream_arbiter.sv - two-requester packet arbiter in front of an AES controller
// Packets are granted whole; an ID FIFO of grant tags routes responses back in order.
module aes_stream_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ID_FIFO_DEPTH = 4
) (
  input  logic                              aes_clk,
  input  logic                              aes_reset,
  input  logic [1:0]                        req_valid,
  input  logic [2*DATA_WIDTH-1:0]           req_data,
  input  logic [1:0]                        req_last,
  output logic [1:0]                        req_ready,
  output logic                              ctl_wren,
  output logic [DATA_WIDTH-1:0]             ctl_data,
  output logic                              ctl_tlast,
  input  logic                              ctl_busy,
  input  logic                              rsp_tvalid,
  input  logic [DATA_WIDTH-1:0]             rsp_tdata,
  input  logic                              rsp_tlast,
  output logic                              rsp_tready,
  output logic [1:0]                        out_tvalid,
  output logic [2*DATA_WIDTH-1:0]           out_tdata,
  output logic [1:0]                        out_tlast,
  input  logic [1:0]                        out_tready,
  output logic [$clog2(ID_FIFO_DEPTH):0]    pending_count
);

  localparam int PTR_W = $clog2(ID_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT0 = 2'd1,
    S_PKT1 = 2'd2
  } state_e;

  state_e                   state_q;
  logic                     last_winner_q;

  logic [ID_FIFO_DEPTH-1:0] tag_mem_q, tag_mem_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     grant_valid;
  logic                     grant_id;
  logic                     active;
  logic                     cur_id;
  logic                     xfer_last;
  logic                     head_id;
  logic                     push;
  logic                     pop;

  assign fifo_full  = (count_q == CNT_W'(ID_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // On a tie the requester that did not win last time goes next.
  assign grant_valid = (state_q == S_IDLE) && !fifo_full && (|req_valid);
  assign grant_id    = (&req_valid) ? ~last_winner_q : req_valid[1];

  assign active = (state_q == S_PKT0) || (state_q == S_PKT1);
  assign cur_id = (state_q == S_PKT1);

  always_comb begin
    req_ready = 2'b00;
    ctl_wren  = 1'b0;
    ctl_data  = '0;
    ctl_tlast = 1'b0;
    if (active) begin
      req_ready[cur_id] = !ctl_busy;
      ctl_wren          = req_valid[cur_id] && !ctl_busy;
      ctl_data          = cur_id ? req_data[DATA_WIDTH +: DATA_WIDTH]
                                 : req_data[0 +: DATA_WIDTH];
      ctl_tlast         = req_last[cur_id];
    end
  end

  assign xfer_last = ctl_wren && req_last[cur_id];

  always_ff @(posedge aes_clk) begin
    if (aes_reset) begin
      state_q       <= S_IDLE;
      last_winner_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_valid) begin
            state_q       <= grant_id ? S_PKT1 : S_PKT0;
            last_winner_q <= grant_id;
          end
        end
        S_PKT0, S_PKT1: begin
          if (xfer_last) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign head_id = tag_mem_q[rd_ptr_q];

  always_comb begin
    out_tvalid = 2'b00;
    out_tlast  = 2'b00;
    rsp_tready = 1'b0;
    if (!fifo_empty) begin
      out_tvalid[head_id] = rsp_tvalid;
      out_tlast[head_id]  = rsp_tlast;
      rsp_tready          = out_tready[head_id];
    end
  end

  assign out_tdata = {2{rsp_tdata}};

  assign push = grant_valid;
  assign pop  = rsp_tvalid && rsp_tready && rsp_tlast;

  // Pointers are exactly PTR_W bits wide, so they wrap modulo the depth.
  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = grant_id;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aes_clk) begin
    if (aes_reset) begin
      tag_mem_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      tag_mem_q <= tag_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign pending_count = count_q;

  a_no_push_full: assert property (@(posedge aes_clk) disable iff (aes_reset)
    !(push && fifo_full));
  a_no_pop_empty: assert property (@(posedge aes_clk) disable iff (aes_reset)
    !(pop && fifo_empty));
  a_count_range: assert property (@(posedge aes_clk) disable iff (aes_reset)
    count_q <= CNT_W'(ID_FIFO_DEPTH));

endmodule

// File: tb/tb_aes_stream_arbiter.sv
// tb/tb_aes_stream_arbiter.sv - directed self-checking bench for aes_stream_arbiter
module tb_aes_stream_arbiter;

  localparam int DW = 32;
  localparam int D  = 4;

  logic            aes_clk = 1'b0;
  logic            aes_reset;
  logic [1:0]      req_valid;
  logic [2*DW-1:0] req_data;
  logic [1:0]      req_last;
  logic [1:0]      req_ready;
  logic            ctl_wren;
  logic [DW-1:0]   ctl_data;
  logic            ctl_tlast;
  logic            ctl_busy;
  logic            rsp_tvalid;
  logic [DW-1:0]   rsp_tdata;
  logic            rsp_tlast;
  logic            rsp_tready;
  logic [1:0]      out_tvalid;
  logic [2*DW-1:0] out_tdata;
  logic [1:0]      out_tlast;
  logic [1:0]      out_tready;
  logic [2:0]      pending_count;

  int errors = 0;
  int checks = 0;

  always #5 aes_clk = ~aes_clk;

  aes_stream_arbiter #(.DATA_WIDTH(DW), .ID_FIFO_DEPTH(D)) dut (
    .aes_clk       (aes_clk),
    .aes_reset     (aes_reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .ctl_wren      (ctl_wren),
    .ctl_data      (ctl_data),
    .ctl_tlast     (ctl_tlast),
    .ctl_busy      (ctl_busy),
    .rsp_tvalid    (rsp_tvalid),
    .rsp_tdata     (rsp_tdata),
    .rsp_tlast     (rsp_tlast),
    .rsp_tready    (rsp_tready),
    .out_tvalid    (out_tvalid),
    .out_tdata     (out_tdata),
    .out_tlast     (out_tlast),
    .out_tready    (out_tready),
    .pending_count (pending_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aes_clk);
    #1;
  endtask

  initial begin
    int w0, w1, p, k;
    logic [1:0] er;
    logic [7:0] busy_pat, wren_pat;

    aes_reset  = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    ctl_busy   = 1'b0;
    rsp_tvalid = 1'b0;
    rsp_tdata  = '0;
    rsp_tlast  = 1'b0;
    out_tready = '0;
    repeat (2) @(posedge aes_clk);
    #1;
    aes_reset = 1'b0;
    #1;
    check("rst_pending", pending_count, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wren", ctl_wren, 0);
    check("rst_rsp_tready", rsp_tready, 0);
    check("rst_out_tvalid", out_tvalid, 0);

    // both requesters valid: 0 granted first, then 1, 5 cycles each
    w0 = 0; w1 = 0;
    for (int c = 0; c < 10; c++) begin
      p = c / 5;
      k = c % 5;
      req_valid = 2'b11;
      req_data  = {32'hB000_0000 | 32'(w1), 32'hA000_0000 | 32'(w0)};
      req_last  = {w1 == 3, w0 == 3};
      #1;
      er = (k == 0) ? 2'b00 : ((p == 0) ? 2'b01 : 2'b10);
      check("alt_ready", req_ready, er);
      check("alt_wren", ctl_wren, k != 0);
      if (k != 0) begin
        check("alt_data", ctl_data, ((p == 0) ? 32'hA000_0000 : 32'hB000_0000) | 32'(k - 1));
        check("alt_tlast", ctl_tlast, k == 4);
      end
      if (er[0]) w0++;
      if (er[1]) w1++;
      tick();
    end
    req_valid = 2'b00;
    #1;
    check("alt_pending", pending_count, 2);
    check("alt_idle_ready", req_ready, 0);

    // requester 0 packet stalled by ctl_busy on word 2 for 3 cycles
    busy_pat = 8'b0011_1000;
    wren_pat = 8'b1100_0110;
    w0 = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 2'b11;
      ctl_busy  = busy_pat[c];
      req_data  = {32'hB000_0000, 32'hA000_0000 | 32'(w0)};
      req_last  = {1'b0, w0 == 3};
      #1;
      check("busy_wren", ctl_wren, wren_pat[c]);
      check("busy_ready", req_ready, {1'b0, wren_pat[c]});
      if (wren_pat[c]) begin
        check("busy_data", ctl_data, 32'hA000_0000 | 32'(w0));
        w0++;
      end
      tick();
    end
    req_valid = 2'b00;
    ctl_busy  = 1'b0;
    #1;
    check("busy_words", w0, 4);
    check("busy_pending", pending_count, 3);

    // responses routed to lanes 0,1,0 following the tag order
    rsp_tvalid = 1'b1;
    rsp_tdata  = 32'h1111_0000;
    rsp_tlast  = 1'b0;
    out_tready = 2'b11;
    #1;
    check("rt_valid0", out_tvalid, 2'b01);
    check("rt_last0", out_tlast, 2'b00);
    check("rt_ready0", rsp_tready, 1);
    check("rt_data0", out_tdata, {32'h1111_0000, 32'h1111_0000});
    tick();
    out_tready = 2'b10;
    #1;
    check("rt_stall0", rsp_tready, 0);
    check("rt_stall_valid0", out_tvalid, 2'b01);
    out_tready = 2'b01;
    rsp_tlast  = 1'b1;
    #1;
    check("rt_ready0b", rsp_tready, 1);
    check("rt_last0b", out_tlast, 2'b01);
    tick();
    rsp_tdata = 32'h2222_0000;
    #1;
    check("rt_head1_stall", rsp_tready, 0);
    check("rt_valid1", out_tvalid, 2'b10);
    check("rt_last1", out_tlast, 2'b10);
    out_tready = 2'b10;
    #1;
    check("rt_ready1", rsp_tready, 1);
    tick();
    out_tready = 2'b01;
    #1;
    check("rt_valid2", out_tvalid, 2'b01);
    check("rt_ready2", rsp_tready, 1);
    tick();
    check("rt_empty_pending", pending_count, 0);
    check("rt_empty_tready", rsp_tready, 0);
    check("rt_empty_valid", out_tvalid, 2'b00);
    rsp_tvalid = 1'b0;
    rsp_tlast  = 1'b0;
    out_tready = 2'b00;

    // five 1-word packets from requester 1 with responses stalled
    req_data = {32'hC000_0001, 32'h0};
    req_last = 2'b10;
    for (int c = 0; c < 8; c++) begin
      req_valid = 2'b10;
      #1;
      check("full_wren", ctl_wren, c % 2);
      check("full_ready", req_ready, (c % 2 == 1) ? 2'b10 : 2'b00);
      tick();
    end
    check("full_pending", pending_count, 4);
    for (int c = 0; c < 2; c++) begin
      check("full_hold_ready", req_ready, 0);
      check("full_hold_wren", ctl_wren, 0);
      tick();
    end
    check("full_still", pending_count, 4);
    rsp_tvalid = 1'b1;
    rsp_tlast  = 1'b1;
    out_tready = 2'b10;
    #1;
    check("full_pop_tready", rsp_tready, 1);
    check("full_pop_valid", out_tvalid, 2'b10);
    tick();
    rsp_tvalid = 1'b0;
    #1;
    check("full_after_pop", pending_count, 3);
    check("full_grant_ready", req_ready, 0);
    tick();
    check("full_regrant", pending_count, 4);
    check("full_fifth_wren", ctl_wren, 1);
    check("full_fifth_data", ctl_data, 32'hC000_0001);
    tick();
    req_valid = 2'b00;

    // simultaneous push and pop at count 2, then reset mid-packet
    rsp_tvalid = 1'b1;
    rsp_tlast  = 1'b1;
    out_tready = 2'b10;
    tick();
    tick();
    check("pp_pre", pending_count, 2);
    req_valid = 2'b01;
    req_data  = {32'h0, 32'hD000_0000};
    req_last  = 2'b00;
    #1;
    check("pp_pop_ready", rsp_tready, 1);
    tick();
    rsp_tvalid = 1'b0;
    #1;
    check("pp_count", pending_count, 2);
    check("pp_wren", ctl_wren, 1);
    tick();
    aes_reset  = 1'b1;
    rsp_tvalid = 1'b1;
    out_tready = 2'b11;
    req_valid  = 2'b11;
    tick();
    check("mid_rst_pending", pending_count, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_wren", ctl_wren, 0);
    check("mid_rst_tready", rsp_tready, 0);
    check("mid_rst_valid", out_tvalid, 0);
    aes_reset  = 1'b0;
    rsp_tvalid = 1'b0;
    #1;
    check("post_rst_grant_cycle", req_ready, 0);
    tick();
    check("post_rst_winner", req_ready, 2'b01);
    check("post_rst_pending", pending_count, 1);
    check("post_rst_data", ctl_data, 32'hD000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
